// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - four-digit common-anode 7-segment scanner with frame-latched mm:ss and alarm blink
module seven_seg_scan #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 125,
  parameter int LZ_BLANK     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] times,
  input  logic [15:0] time_out,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [PW-1:0] PS_LAST    = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic {NORMAL, ALARM} state_t;

  state_t        state, state_n;
  logic [PW-1:0] prescaler;
  logic [1:0]    idx, idx_n;
  logic [15:0]   disp_val, disp_n;
  logic          alarm_lat, alarm_n;
  logic [BW-1:0] blink_cnt, blink_n;
  logic          phase_on, phase_n;
  logic          tick, boundary;
  logic [3:0]    nib;
  logic [3:0]    an_n;
  logic [6:0]    seg_n;
  logic          dp_n;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Everything below is the value the registers take on the next tick, so the
  // outputs are decoded from the new digit, new sample and new blink phase.
  always_comb begin
    tick     = (prescaler == PS_LAST);
    boundary = tick && (idx == 2'd3);
    idx_n    = idx + 2'd1;
    disp_n   = boundary ? times : disp_val;
    alarm_n  = boundary ? (|time_out) : alarm_lat;
    state_n  = state;
    blink_n  = blink_cnt;
    phase_n  = phase_on;
    if (boundary) begin
      case (state)
        NORMAL: begin
          if (alarm_n) begin
            state_n = ALARM;
            blink_n = '0;
            phase_n = 1'b1;
          end
        end
        default: begin
          if (!alarm_n) begin
            state_n = NORMAL;
            blink_n = '0;
            phase_n = 1'b1;
          end else if (blink_cnt == BLINK_LAST) begin
            blink_n = '0;
            phase_n = !phase_on;
          end else begin
            blink_n = blink_cnt + BW'(1);
          end
        end
      endcase
    end

    nib   = disp_n[{idx_n, 2'b00} +: 4];
    an_n  = ~(4'b0001 << idx_n);
    seg_n = decode(nib);
    dp_n  = (idx_n != 2'd2);
    if ((LZ_BLANK != 0) && (idx_n == 2'd3) && (nib == 4'd0)) begin
      seg_n = 7'h7F;
    end
    if (!phase_n) begin
      an_n = 4'b1111;
      dp_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescaler  <= '0;
      idx        <= 2'd0;
      disp_val   <= 16'h0000;
      alarm_lat  <= 1'b0;
      state      <= NORMAL;
      blink_cnt  <= '0;
      phase_on   <= 1'b1;
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      prescaler  <= tick ? '0 : prescaler + PW'(1);
      if (tick) begin
        idx       <= idx_n;
        disp_val  <= disp_n;
        alarm_lat <= alarm_n;
        state     <= state_n;
        blink_cnt <= blink_n;
        phase_on  <= phase_n;
        an        <= an_n;
        seg       <= seg_n;
        dp        <= dp_n;
      end
    end
  end

endmodule
